// File: rtl/vram_rect_fill.sv
// vram_rect_fill: rectangle-fill write engine for the GPU frame buffer.
// Accepts a corner-pair plus colour command, clips it to the visible area
// and streams one VRAM write per cycle in row-major order, pausing while
// a higher-priority master owns the VRAM port.
module vram_rect_fill #(
  parameter int H_RES  = 200,
  parameter int V_RES  = 150,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [7:0]        x0_i,
  input  logic [7:0]        y0_i,
  input  logic [7:0]        x1_i,
  input  logic [7:0]        y1_i,
  input  logic [DATA_W-1:0] color_i,
  input  logic              stall_i,
  output logic              vram_we_o,
  output logic [15:0]       vram_addr_o,
  output logic [DATA_W-1:0] vram_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [7:0] H_MAX = 8'(H_RES - 1);
  localparam logic [7:0] V_MAX = 8'(V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [7:0]          h_r;
  logic [7:0]          v_r;
  logic [7:0]          x0_r;
  logic [7:0]          cx1_r;
  logic [7:0]          cy1_r;
  logic [DATA_W-1:0]   color_r;
  logic [7:0]          cx1_s;
  logic [7:0]          cy1_s;
  logic                accept_s;
  logic                empty_s;
  logic                adv_s;
  logic                last_s;

  // Clip the incoming command and decode accept / advance / last-pixel events.
  always_comb begin
    cx1_s    = (x1_i > H_MAX) ? H_MAX : x1_i;
    cy1_s    = (y1_i > V_MAX) ? V_MAX : y1_i;
    accept_s = (state_r == S_IDLE) && cmd_valid_i;
    // An origin past the clipped far edge also catches fully off-screen origins.
    empty_s  = (x0_i > cx1_s) || (y0_i > cy1_s);
    adv_s    = (state_r == S_FILL) && !stall_i;
    last_s   = (h_r == cx1_r) && (v_r == cy1_r);
  end

  // Next-state logic for the IDLE -> FILL -> DONE sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_next_s = empty_s ? S_DONE : S_FILL;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_FILL: begin
        if (adv_s && last_s) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_FILL;
        end
      end
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // State register; reset abandons any fill in progress without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Command latch and raster counters; an empty command leaves address/data untouched,
  // and the final pixel does not advance so the address holds on the last write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_r     <= 8'd0;
      v_r     <= 8'd0;
      x0_r    <= 8'd0;
      cx1_r   <= 8'd0;
      cy1_r   <= 8'd0;
      color_r <= {DATA_W{1'b0}};
    end else if (accept_s && !empty_s) begin
      h_r     <= x0_i;
      v_r     <= y0_i;
      x0_r    <= x0_i;
      cx1_r   <= cx1_s;
      cy1_r   <= cy1_s;
      color_r <= color_i;
    end else if (adv_s && !last_s) begin
      if (h_r < cx1_r) begin
        h_r <= h_r + 8'd1;
      end else begin
        h_r <= x0_r;
        v_r <= v_r + 8'd1;
      end
    end
  end

  assign cmd_ready_o = (state_r == S_IDLE);
  assign busy_o      = (state_r != S_IDLE);
  assign done_o      = (state_r == S_DONE);
  assign vram_we_o   = (state_r == S_FILL) && !stall_i;
  assign vram_addr_o = {v_r, h_r};
  assign vram_data_o = color_r;

endmodule

// File: doc/vram_rect_fill.md
Name: vram_rect_fill

Overview:
- Upstream write-side engine for the GPU video memory. Accepts a rectangle-fill command (corners plus 12-bit RGB colour) and issues one VRAM write per cycle.
- Drives the GPU write port: vram_we_i, vram_data_i, and vram_addr_i, where the address is {v,h} with v in the top byte and h in the bottom byte.
- Provides CPU-side clear/fill acceleration for the 200x150 frame buffer. A top-level mux selects this engine's port while busy_o=1.

Parameters:
- H_RES, 200, display width in pixels; valid h is 0..H_RES-1.
- V_RES, 150, display height in pixels; valid v is 0..V_RES-1.
- DATA_W, 12, pixel width (RGB 4:4:4).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  engine can accept a command (IDLE only).
- x0_i  in  8  left column, inclusive.
- y0_i  in  8  top row, inclusive.
- x1_i  in  8  right column, inclusive.
- y1_i  in  8  bottom row, inclusive.
- color_i  in  DATA_W  fill colour.
- stall_i  in  1  VRAM port taken by a higher-priority master; pause writes.
- vram_we_o  out  1  write strobe to the GPU.
- vram_addr_o  out  16  {v[7:0], h[7:0]}.
- vram_data_o  out  DATA_W  pixel colour.
- busy_o  out  1  high in FILL and DONE.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset: asynchronous and active-low; takes effect immediately and returns the engine to IDLE. Reset values:
  - state=IDLE, cmd_ready_o=1, busy_o=0, done_o=0, vram_we_o=0.
  - vram_addr_o=0, vram_data_o=0, all counters 0.
- Reset mid-fill: writes stop immediately; done_o is not pulsed; any remaining pixels are abandoned.
- States: IDLE, FILL, DONE (2-bit register).
- IDLE:
  - cmd_ready_o=1.
  - Accept occurs on a rising edge where cmd_valid_i=1 and cmd_ready_o=1. On accept, latch color_i and the clipped bounds:
    - cx1 = min(x1_i, H_RES-1)
    - cy1 = min(y1_i, V_RES-1)
  - Rectangle is empty if x0_i>cx1 or y0_i>cy1. This also covers x0_i>=H_RES and y0_i>=V_RES.
  - Empty: go to DONE. Non-empty: set h=x0_i, v=y0_i and go to FILL.
  - Inputs are ignored while cmd_ready_o=0. The command is sampled only at accept; later input changes have no effect.
- FILL:
  - vram_we_o = ~stall_i (combinational).
  - vram_addr_o = {v,h}; vram_data_o = latched colour.
  - On each edge with stall_i=0: if h<cx1, h++; else h=x0 and v++.
  - On the write where h==cx1 and v==cy1, go to DONE.
  - While stall_i=1: no write, counters hold, addr/data hold.
- Write order: row-major, left to right then top to bottom, exactly one write per pixel, no duplicates.
- DONE: done_o=1 and busy_o=1 for exactly one cycle, vram_we_o=0; then IDLE.
- Timing, accept at edge N, no stalls, W=cx1-x0+1, H=cy1-y0+1:
  - first write visible in cycle N+1;
  - last write in cycle N+W*H;
  - done_o in cycle N+W*H+1;
  - cmd_ready_o=1 from cycle N+W*H+2.
- Empty rectangle: done_o in cycle N+1, no writes.
- Each stalled cycle delays all later events by one cycle.
- Arithmetic: h and v are 8-bit and cannot overflow, because clipping bounds them to 199 and 149. Comparisons are unsigned.
- Outside FILL: vram_we_o=0; vram_addr_o and vram_data_o hold their last values.

Test Plan:
- Single pixel: x0=x1=5, y0=y1=7, colour 0xF00 -> one write, addr 0x0705, data 0xF00; done_o 2 cycles after accept.
- Full clear: 0,0,255,255, colour 0x000 -> writes clipped to 200x150, exactly 30000 writes; first addr 0x0000, last 0x95C7, 0x00C7 follows 0x00C6 and is followed by 0x0100; done_o at N+30001.
- Right-edge clip: x0=190, x1=250, y0=10, y1=11 -> 20 writes, addr 0x0ABE..0x0AC7 then 0x0BBE..0x0BC7.
- Empty and offscreen: x0=5, x1=3 -> no writes, done_o at N+1. Then x0=220 -> same result.
- Stall: 4x1 rect with stall_i high for 3 cycles after the 2nd write -> vram_we_o=0 for those cycles, addr held at the 3rd pixel, exactly 4 writes total, done_o delayed by 3 cycles; a cmd_valid_i pulse during FILL is ignored.
- Reset mid-fill: rst_n low after 10 writes of a 20x20 rect -> vram_we_o=0 immediately, no done_o; after release cmd_ready_o=1 and a new command fills correctly.
